// File: rtl/score_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : score_bcd_converter
// Description : Sequential binary-to-packed-BCD converter feeding the 4-digit
//               seven-segment driver. Iterative double-dabble, one input bit
//               per clock. The last completed result is held on bcd_out, so
//               the display never sees a partial conversion. Inputs above
//               SAT_VALUE are clamped to SAT_VALUE and flagged on overflow.
//               Optional macro LEADING_ZERO_BLANK_EN replaces leading zero
//               digits (thousands..tens) with 4'hF, which the display blanks.
// Revision    : 1.0 - initial release
// ============================================================================
module score_bcd_converter #(
    parameter int BIN_W     = 14,
    parameter int SAT_VALUE = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd_out,
    output logic             overflow
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               c_SR_W    = 16 + BIN_W;      // {bcd, bin}
    localparam int               c_CNT_W   = $clog2(BIN_W);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BIN_W - 1);
    localparam logic [BIN_W-1:0] c_SAT     = BIN_W'(SAT_VALUE);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_SR_W-1:0]  r_shift;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ovf_pend;
    logic               r_busy;
    logic               r_done;
    logic [15:0]        r_bcd_out;
    logic               r_overflow;

    logic               w_ovf;
    logic [BIN_W-1:0]   w_operand;
    logic [15:0]        w_bcd_adj;
    logic [c_SR_W-1:0]  w_shift_adj;

    // Clamp out-of-range scores before conversion.
    assign w_ovf     = (bin_in > c_SAT);
    assign w_operand = w_ovf ? c_SAT : bin_in;

    // Double-dabble correction: each BCD digit >= 5 gets +3 before the shift,
    // so the shift carries it correctly into the next decimal digit.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nibble
            logic [3:0] w_dig;
            assign w_dig = r_shift[BIN_W + 4*gi +: 4];
            assign w_bcd_adj[4*gi +: 4] = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
        end
    endgenerate

    assign w_shift_adj = {w_bcd_adj, r_shift[BIN_W-1:0]};

    // Optional leading-zero blanking; the units digit is always shown.
    function automatic logic [15:0] f_format(input logic [15:0] b);
        logic [15:0] v_res;
        v_res = b;
`ifdef LEADING_ZERO_BLANK_EN
        if (b[15:12] == 4'h0) begin
            v_res[15:12] = 4'hF;
            if (b[11:8] == 4'h0) begin
                v_res[11:8] = 4'hF;
                if (b[7:4] == 4'h0) begin
                    v_res[7:4] = 4'hF;
                end
            end
        end
`endif
        return v_res;
    endfunction

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic: accept in IDLE, BIN_W shift steps, one DONE cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_state_nxt = c_ST_SHIFT;
            c_ST_SHIFT: if (r_cnt == c_LAST) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Datapath: latch operand, iterate the shift register, publish result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd_out  <= 16'h0000;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_shift    <= {16'h0000, w_operand};
                        r_ovf_pend <= w_ovf;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                c_ST_SHIFT: begin
                    r_shift <= w_shift_adj << 1;
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                end
                c_ST_DONE: begin
                    r_bcd_out  <= f_format(r_shift[BIN_W +: 16]);
                    r_overflow <= r_ovf_pend;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd_out  = r_bcd_out;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_bcd_converter
// Description : Scoreboard bench for score_bcd_converter. A driver issues
//               start requests and pushes the expected result computed with
//               plain decimal arithmetic; a monitor pops and compares on done
//               and checks busy and the held outputs every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_bcd_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    score_bcd_converter #(
        .BIN_W     (14),
        .SAT_VALUE (9999)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          acc_edge;
        int          done_cyc;
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          next_ok = 0;
    bit          rst_pending = 0;
    bit          chk_en = 0;
    logic [15:0] hold_bcd = 16'h0000;
    logic        hold_ovf = 1'b0;

    // Reference: clamp, split into decimal digits, optionally blank.
    function automatic logic [15:0] ref_bcd(input int x);
        int v;
        logic [3:0] d3, d2, d1, d0;
        v  = (x > 9999) ? 9999 : x;
        d3 = 4'(v / 1000);
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
`ifdef LEADING_ZERO_BLANK_EN
        if (d3 == 0) begin
            d3 = 4'hF;
            if (d2 == 0) begin
                d2 = 4'hF;
                if (d1 == 0) d1 = 4'hF;
            end
        end
`endif
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [13:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return 14'($urandom_range(0, 16383));
            1:       return 14'($urandom_range(9990, 10010));
            2:       return 14'($urandom_range(0, 99));
            default: return 14'($urandom_range(0, 9999));
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // One driver cycle: apply inputs after the edge and update the model.
    task automatic step(input logic st, input logic [13:0] v, input logic r);
        exp_t e;
        @(posedge clk);
        #2;
        if (rst_pending) begin
            q.delete();
            hold_bcd    = 16'h0000;
            hold_ovf    = 1'b0;
            next_ok     = cyc + 1;
            rst_pending = 0;
            chk_en      = 1;
        end
        rst    = r;
        start  = st;
        bin_in = v;
        if (r) begin
            rst_pending = 1;
        end else if (st && (cyc + 1 >= next_ok)) begin
            e.acc_edge = cyc + 1;
            e.done_cyc = cyc + 16;
            e.bcd      = ref_bcd(int'(v));
            e.ovf      = (v > 14'd9999);
            q.push_back(e);
            next_ok    = cyc + 17;
        end
    endtask

    task automatic convert(input logic [13:0] v);
        step(1'b1, v, 1'b0);
        repeat (16) step(1'b0, rand_val(), 1'b0);
    endtask

    // Monitor: compare on done, and check busy and held outputs every cycle.
    initial begin
        logic exp_busy;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_busy = (q.size() > 0) && (cyc >= q[0].acc_edge) && (cyc < q[0].done_cyc);
                chk("busy", {31'b0, busy}, {31'b0, exp_busy});
                if (done) begin
                    if (q.size() == 0) begin
                        chk("spurious_done", {31'b0, done}, 32'd0);
                    end else begin
                        chk("latency", cyc, q[0].done_cyc);
                        chk("bcd_out", {16'b0, bcd_out}, {16'b0, q[0].bcd});
                        chk("overflow", {31'b0, overflow}, {31'b0, q[0].ovf});
                        hold_bcd = q[0].bcd;
                        hold_ovf = q[0].ovf;
                        void'(q.pop_front());
                    end
                end else if (q.size() > 0 && cyc >= q[0].done_cyc) begin
                    chk("missing_done", {31'b0, done}, 32'd1);
                    void'(q.pop_front());
                end
                chk("bcd_hold", {16'b0, bcd_out}, {16'b0, hold_bcd});
                chk("ovf_hold", {31'b0, overflow}, {31'b0, hold_ovf});
            end
        end
    end

    // Driver
    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) step(1'b0, 14'd0, 1'b1);
        step(1'b0, 14'd0, 1'b0);
        @(negedge clk);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_bcd", {16'b0, bcd_out}, 32'd0);

        // Directed values and boundaries
        convert(14'd1234);
        convert(14'd9999);
        convert(14'd0);
        convert(14'd12000);
        convert(14'd7);
        convert(14'd9);
        convert(14'd10);
        convert(14'd305);
        convert(14'd1000);
        convert(14'd10000);
        convert(14'd16383);

        // Start during busy is ignored; bin_in churns every cycle.
        step(1'b1, 14'd1234, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            if (i == 5) step(1'b1, 14'd5678, 1'b0);
            else        step(1'b0, rand_val(), 1'b0);
        end

        // Reset mid-conversion aborts without done.
        step(1'b1, 14'd4321, 1'b0);
        repeat (7) step(1'b0, rand_val(), 1'b0);
        step(1'b0, rand_val(), 1'b1);
        convert(14'd50);

        // Start held high: back-to-back conversions every 16 cycles.
        repeat (160) step(1'b1, rand_val(), 1'b0);
        repeat (16) step(1'b0, 14'd0, 1'b0);

        // Random single conversions, sometimes with stray starts while busy.
        for (int n = 0; n < 150; n++) begin
            step(1'b1, rand_val(), 1'b0);
            repeat (16) step(($urandom_range(0, 7) == 0), rand_val(), 1'b0);
        end

        repeat (20) step(1'b0, 14'd0, 1'b0);
        chk("drain", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
